// File: rtl/nebula_link_vc_sched_pkg.sv
// Shared types and constants for the Nebula link TX scheduler.
package nebula_link_vc_sched_pkg;

  // Link flit width and the width of every VC index field on the link interface.
  localparam int FLIT_W = 32;
  localparam int VC_W   = 8;

  typedef enum logic [1:0] {
    LINK_IDLE  = 2'd0,
    LINK_RUN   = 2'd1,
    LINK_DRAIN = 2'd2
  } link_fsm_e;

endpackage

// File: rtl/nebula_link_vc_sched_rr_arb.sv
// Round-robin arbiter: picks the first request at or after the pointer, wrapping.
module nebula_link_vc_sched_rr_arb #(
  parameter int  N  = 4,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic          any_grant_o
);

  int   idx;
  logic found;

  // Scan N positions starting at the pointer; the first hit wins.
  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = 0;
    for (int off = 0; off < N; off++) begin
      idx = (int'(ptr_i) + off) % N;
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  assign any_grant_o = found;

endmodule

// File: rtl/nebula_link_vc_sched.sv
// Nebula link TX scheduler: round-robin over per-VC queues with credit flow control,
// a single output register toward the link, and a registered outbound credit path.
//
//  state      | meaning
//  -----------+-------------------------------------------------------------
//  LINK_IDLE  | link disabled, no grants; leaves when link_en rises
//  LINK_RUN   | grants issued whenever the output slot is free
//  LINK_DRAIN | no new grants; waits for the held flit to be accepted
module nebula_link_vc_sched
  import nebula_link_vc_sched_pkg::*;
#(
  parameter int  FLIT_WI        = FLIT_W,
  parameter int  NUM_VC         = 4,
  parameter int  CREDITS_PER_VC = 8,
  localparam int CNT_W          = $clog2(CREDITS_PER_VC + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      link_en,
  input  logic [NUM_VC-1:0]         vc_in_valid,
  input  logic [NUM_VC*FLIT_WI-1:0] vc_in_flit,
  output logic [NUM_VC-1:0]         vc_in_ready,
  output logic                      tx_valid,
  output logic [FLIT_WI-1:0]        tx_flit,
  input  logic                      rx_ready,
  input  logic                      credit_rx_valid,
  input  logic [VC_W-1:0]           credit_rx_vc,
  input  logic                      rxbuf_free,
  input  logic [VC_W-1:0]           rxbuf_free_vc,
  output logic                      credit_tx_valid,
  output logic [VC_W-1:0]           credit_tx_vc,
  output logic [NUM_VC*CNT_W-1:0]   credit_cnt,
  output logic                      link_idle,
  output logic [1:0]                err_sticky
);

  localparam int               PW      = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CREDITS_PER_VC);

  link_fsm_e            state_q;
  logic [PW-1:0]        ptr_q, ptr_d;
  logic                 tx_valid_q;
  logic [FLIT_WI-1:0]   tx_flit_q;
  logic [1:0]           err_q, err_d;
  logic                 ctx_valid_q;
  logic [VC_W-1:0]      ctx_vc_q;

  logic                 slot_free;
  logic                 grant_en;
  logic [NUM_VC-1:0]    eligible;
  logic [NUM_VC-1:0]    req;
  logic [NUM_VC-1:0]    gnt;
  logic                 any_grant;
  logic [PW-1:0]        gnt_idx;
  logic [FLIT_WI-1:0]   flit_sel;
  logic [NUM_VC-1:0]    ovf;
  logic                 bad_vc;

  assign slot_free = !tx_valid_q || rx_ready;
  assign grant_en  = (state_q == LINK_RUN) && slot_free;
  assign req       = eligible & {NUM_VC{grant_en}};

  nebula_link_vc_sched_rr_arb #(.N(NUM_VC)) u_arb (
    .req_i       (req),
    .ptr_i       (ptr_q),
    .gnt_o       (gnt),
    .any_grant_o (any_grant)
  );

  // Encode the one-hot grant and steer the granted queue's head flit.
  always_comb begin
    gnt_idx  = '0;
    flit_sel = '0;
    for (int i = 0; i < NUM_VC; i++) begin
      if (gnt[i]) begin
        gnt_idx  = PW'(i);
        flit_sel = vc_in_flit[i*FLIT_WI +: FLIT_WI];
      end
    end
  end

  assign ptr_d = (gnt_idx == PW'(NUM_VC - 1)) ? '0 : gnt_idx + 1'b1;

  // Per-VC credit counters: decrement on grant, increment on far-end return,
  // saturating at the far-end buffer depth.
  for (genvar gi = 0; gi < NUM_VC; gi++) begin : g_credit
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             inc, dec;

    assign inc          = credit_rx_valid && (credit_rx_vc == VC_W'(gi));
    assign dec          = gnt[gi];
    assign ovf[gi]      = inc && !dec && (cnt_q == CNT_MAX);
    assign eligible[gi] = vc_in_valid[gi] && (cnt_q != '0);
    assign credit_cnt[gi*CNT_W +: CNT_W] = cnt_q;

    // Next credit count; simultaneous grant and return cancel out.
    always_comb begin
      cnt_d = cnt_q;
      if (inc && !dec && (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + 1'b1;
      end else if (dec && !inc) begin
        cnt_d = cnt_q - 1'b1;
      end
    end

    // Credit counter register; reset restores the full far-end allowance.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= CNT_MAX;
      end else begin
        cnt_q <= cnt_d;
      end
    end
  end

  assign bad_vc = credit_rx_valid && (credit_rx_vc >= VC_W'(NUM_VC));
  assign err_d  = err_q | {bad_vc, |ovf};

  // Link state machine.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LINK_IDLE;
    end else begin
      case (state_q)
        LINK_IDLE:  if (link_en) state_q <= LINK_RUN;
        LINK_RUN:   if (!link_en) state_q <= LINK_DRAIN;
        LINK_DRAIN: begin
          if (link_en) begin
            state_q <= LINK_RUN;
          end else if (!tx_valid_q) begin
            state_q <= LINK_IDLE;
          end
        end
        default:    state_q <= LINK_IDLE;
      endcase
    end
  end

  // Output register and RR pointer: load on grant, hold under backpressure,
  // empty once the far end accepts and nothing new was granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_valid_q <= 1'b0;
      tx_flit_q  <= '0;
      ptr_q      <= '0;
    end else if (any_grant) begin
      tx_valid_q <= 1'b1;
      tx_flit_q  <= flit_sel;
      ptr_q      <= ptr_d;
    end else if (rx_ready) begin
      tx_valid_q <= 1'b0;
    end
  end

  // Sticky errors and the registered outbound credit pass-through.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q       <= '0;
      ctx_valid_q <= 1'b0;
      ctx_vc_q    <= '0;
    end else begin
      err_q       <= err_d;
      ctx_valid_q <= rxbuf_free;
      ctx_vc_q    <= rxbuf_free_vc;
    end
  end

  assign vc_in_ready     = gnt;
  assign tx_valid        = tx_valid_q;
  assign tx_flit         = tx_flit_q;
  assign credit_tx_valid = ctx_valid_q;
  assign credit_tx_vc    = ctx_vc_q;
  assign err_sticky      = err_q;
  assign link_idle       = (state_q == LINK_IDLE) && !tx_valid_q;

endmodule

// File: tb/tb_nebula_link_vc_sched.sv
// Directed bench for the Nebula link TX scheduler (NUM_VC=4, 8 credits per VC).
module tb_nebula_link_vc_sched;
  import nebula_link_vc_sched_pkg::*;

  localparam int NVC = 4;
  localparam int FW  = FLIT_W;
  localparam int CW  = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              link_en = 1'b0;
  logic [NVC-1:0]    vc_in_valid = '0;
  logic [NVC*FW-1:0] vc_in_flit;
  logic [NVC-1:0]    vc_in_ready;
  logic              tx_valid;
  logic [FW-1:0]     tx_flit;
  logic              rx_ready = 1'b0;
  logic              credit_rx_valid = 1'b0;
  logic [7:0]        credit_rx_vc = '0;
  logic              rxbuf_free = 1'b0;
  logic [7:0]        rxbuf_free_vc = '0;
  logic              credit_tx_valid;
  logic [7:0]        credit_tx_vc;
  logic [NVC*CW-1:0] credit_cnt;
  logic              link_idle;
  logic [1:0]        err_sticky;

  nebula_link_vc_sched #(.FLIT_WI(FW), .NUM_VC(NVC), .CREDITS_PER_VC(8)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .link_en         (link_en),
    .vc_in_valid     (vc_in_valid),
    .vc_in_flit      (vc_in_flit),
    .vc_in_ready     (vc_in_ready),
    .tx_valid        (tx_valid),
    .tx_flit         (tx_flit),
    .rx_ready        (rx_ready),
    .credit_rx_valid (credit_rx_valid),
    .credit_rx_vc    (credit_rx_vc),
    .rxbuf_free      (rxbuf_free),
    .rxbuf_free_vc   (rxbuf_free_vc),
    .credit_tx_valid (credit_tx_valid),
    .credit_tx_vc    (credit_tx_vc),
    .credit_cnt      (credit_cnt),
    .link_idle       (link_idle),
    .err_sticky      (err_sticky)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic           en;
    logic [NVC-1:0] vv;
    logic           rr;
    logic [NVC-1:0] exp_rdy;
    logic           exp_txv;
    logic [FW-1:0]  exp_flit;
    logic [15:0]    exp_cnt;
  } vec_t;

  vec_t tv[10];
  int   checks = 0;
  int   errors = 0;
  int   pops;

  function automatic logic [FW-1:0] fl(input int i);
    return 32'hC0DE_0000 | FW'(i);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rst_pulse();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    vc_in_flit = {fl(3), fl(2), fl(1), fl(0)};

    //           en  vv     rr  rdy    txv  flit    cnt
    tv[0] = '{1'b1, 4'hF, 1'b1, 4'h0, 1'b0, '0,     16'h8888};
    tv[1] = '{1'b1, 4'hF, 1'b1, 4'h1, 1'b1, fl(0), 16'h8887};
    tv[2] = '{1'b1, 4'hF, 1'b1, 4'h2, 1'b1, fl(1), 16'h8877};
    tv[3] = '{1'b1, 4'hF, 1'b1, 4'h4, 1'b1, fl(2), 16'h8777};
    tv[4] = '{1'b1, 4'hF, 1'b1, 4'h8, 1'b1, fl(3), 16'h7777};
    tv[5] = '{1'b1, 4'hF, 1'b1, 4'h1, 1'b1, fl(0), 16'h7776};
    tv[6] = '{1'b1, 4'hF, 1'b1, 4'h2, 1'b1, fl(1), 16'h7766};
    tv[7] = '{1'b1, 4'hF, 1'b1, 4'h4, 1'b1, fl(2), 16'h7666};
    tv[8] = '{1'b1, 4'hF, 1'b1, 4'h8, 1'b1, fl(3), 16'h6666};
    tv[9] = '{1'b1, 4'h0, 1'b1, 4'h0, 1'b0, fl(3), 16'h6666};

    // Reset state
    #12;
    chk("rst_cnt", credit_cnt, 16'h8888);
    chk("rst_txv", tx_valid, 0);
    chk("rst_idle", link_idle, 1);
    chk("rst_err", err_sticky, 0);
    chk("rst_rdy", vc_in_ready, 0);
    chk("rst_ctxv", credit_tx_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Round-robin over all four VCs
    for (int k = 0; k < 10; k++) begin
      link_en     = tv[k].en;
      vc_in_valid = tv[k].vv;
      rx_ready    = tv[k].rr;
      #1;
      chk($sformatf("rr%0d_rdy", k), vc_in_ready, tv[k].exp_rdy);
      tick();
      chk($sformatf("rr%0d_txv", k), tx_valid, tv[k].exp_txv);
      chk($sformatf("rr%0d_flit", k), tx_flit, tv[k].exp_flit);
      chk($sformatf("rr%0d_cnt", k), credit_cnt, tv[k].exp_cnt);
    end

    // Credit exhaustion on VC2
    link_en = 1'b0;
    rst_pulse();
    link_en     = 1'b1;
    vc_in_valid = 4'h4;
    rx_ready    = 1'b1;
    pops = 0;
    for (int k = 0; k < 14; k++) begin
      #1;
      if (vc_in_ready[2]) pops++;
      tick();
    end
    chk("exh_pops", pops, 8);
    #1;
    chk("exh_rdy", vc_in_ready, 0);
    chk("exh_cnt", credit_cnt, 16'h8088);
    credit_rx_valid = 1'b1;
    credit_rx_vc    = 8'd2;
    tick();
    credit_rx_valid = 1'b0;
    chk("exh_ret_cnt", credit_cnt, 16'h8188);
    pops = 0;
    for (int k = 0; k < 5; k++) begin
      #1;
      if (vc_in_ready[2]) pops++;
      tick();
    end
    chk("exh_extra_pops", pops, 1);
    chk("exh_cnt2", credit_cnt, 16'h8088);

    // Backpressure: held flit stays put while the queue head changes
    vc_in_valid = 4'h1;
    rx_ready    = 1'b0;
    #1;
    chk("bp_rdy0", vc_in_ready, 4'h1);
    tick();
    chk("bp_txv0", tx_valid, 1);
    chk("bp_cnt0", credit_cnt, 16'h8087);
    vc_in_flit[FW-1:0] = 32'h5A5A_0000;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("bp%0d_rdy", k), vc_in_ready, 0);
      tick();
      chk($sformatf("bp%0d_flit", k), tx_flit, fl(0));
      chk($sformatf("bp%0d_txv", k), tx_valid, 1);
      chk($sformatf("bp%0d_cnt", k), credit_cnt, 16'h8087);
    end
    rx_ready = 1'b1;
    #1;
    chk("bp_rel_rdy", vc_in_ready, 4'h1);
    tick();
    chk("bp_rel_flit", tx_flit, 32'h5A5A_0000);
    chk("bp_rel_cnt", credit_cnt, 16'h8086);
    vc_in_valid = 4'h0;
    tick();
    chk("bp_empty", tx_valid, 0);

    // Simultaneous grant/return, bad VC, overflow, outbound credit
    vc_in_flit[FW-1:0] = fl(0);
    link_en = 1'b0;
    rst_pulse();
    link_en     = 1'b1;
    vc_in_valid = 4'h2;
    tick();
    #1;
    chk("sim_rdy0", vc_in_ready, 4'h2);
    tick();
    chk("sim_cnt0", credit_cnt, 16'h8878);
    credit_rx_valid = 1'b1;
    credit_rx_vc    = 8'd1;
    #1;
    chk("sim_rdy1", vc_in_ready, 4'h2);
    tick();
    chk("sim_cnt1", credit_cnt, 16'h8878);
    chk("sim_err1", err_sticky, 2'b00);
    vc_in_valid  = 4'h0;
    credit_rx_vc = 8'd7;
    tick();
    chk("badvc_err", err_sticky, 2'b10);
    chk("badvc_cnt", credit_cnt, 16'h8878);
    credit_rx_vc = 8'd1;
    tick();
    chk("ret_cnt", credit_cnt, 16'h8888);
    chk("ret_err", err_sticky, 2'b10);
    tick();
    chk("ovf_cnt", credit_cnt, 16'h8888);
    chk("ovf_err", err_sticky, 2'b11);
    credit_rx_valid = 1'b0;
    rxbuf_free    = 1'b1;
    rxbuf_free_vc = 8'd5;
    tick();
    chk("ctx_valid", credit_tx_valid, 1);
    chk("ctx_vc", credit_tx_vc, 8'd5);
    rxbuf_free = 1'b0;
    tick();
    chk("ctx_clear", credit_tx_valid, 0);

    // Drain with a held flit
    vc_in_valid = 4'h1;
    rx_ready    = 1'b0;
    #1;
    chk("dr_rdy0", vc_in_ready, 4'h1);
    tick();
    chk("dr_txv0", tx_valid, 1);
    link_en = 1'b0;
    #1;
    chk("dr_rdy1", vc_in_ready, 0);
    tick();
    #1;
    chk("dr_rdy2", vc_in_ready, 0);
    tick();
    chk("dr_idle0", link_idle, 0);
    chk("dr_txv1", tx_valid, 1);
    rx_ready = 1'b1;
    #1;
    chk("dr_rdy3", vc_in_ready, 0);
    tick();
    chk("dr_txv2", tx_valid, 0);
    chk("dr_idle1", link_idle, 0);
    tick();
    chk("dr_idle2", link_idle, 1);

    // Reset mid-stream
    link_en     = 1'b1;
    vc_in_valid = 4'hF;
    rx_ready    = 1'b0;
    tick();
    tick();
    chk("mr_txv_pre", tx_valid, 1);
    rst_n = 1'b0;
    #2;
    chk("mr_txv", tx_valid, 0);
    chk("mr_cnt", credit_cnt, 16'h8888);
    chk("mr_rdy", vc_in_ready, 0);
    chk("mr_idle", link_idle, 1);
    chk("mr_err", err_sticky, 0);
    #2;
    rst_n = 1'b1;
    vc_in_valid = 4'h0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
